// File: rtl/router_reg_if.sv
// router_reg_if: bundles the source byte stream, the router FSM state strobes
// and the datapath status returned to the FSM into one connection.
// master: the FSM/source side that drives the strobes and bytes.
// slave : the router_reg datapath side.
interface router_reg_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  pkt_valid;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  fifo_full;
    logic                  detect_add;
    logic                  lfd_state;
    logic                  ld_state;
    logic                  laf_state;
    logic                  full_state;
    logic                  rst_int_reg;
    logic [DATA_WIDTH-1:0] dout;
    logic                  parity_done;
    logic                  low_pkt_valid;
    logic                  err;
    logic                  len_err;

    modport master (
        output pkt_valid, data_in, fifo_full,
        output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
        input  dout, parity_done, low_pkt_valid, err, len_err
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full,
        input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
        output dout, parity_done, low_pkt_valid, err, len_err
    );
endinterface

// File: rtl/router_reg.sv
// router_reg: datapath register stage behind the 1x3 router control FSM.
// Latches the header, forwards bytes to the selected output FIFO, parks a
// byte across FIFO-full stalls, accumulates running parity and reports
// parity_done / low_pkt_valid / err back to the FSM.
// Optional length check: define ROUTER_REG_LEN_CHECK_EN to build the payload
// counter driving len_err; otherwise len_err is tied low.
module router_reg #(
    parameter int DATA_WIDTH = 8
) (
    input logic        clk,
    input logic        rst,
    router_reg_if.slave bus
);

    logic [DATA_WIDTH-1:0] dout_q;
    logic [DATA_WIDTH-1:0] header_reg;
    logic [DATA_WIDTH-1:0] hold_reg;
    logic [DATA_WIDTH-1:0] int_parity;
    logic [DATA_WIDTH-1:0] pkt_parity;
    logic                  parity_done_q;
    logic                  low_pkt_valid_q;
    logic                  err_q;

    logic header_ok;
    logic ld_write;
    logic ld_stall;

    // Decode of the byte-acceptance conditions shared by the register blocks.
    always_comb begin
        header_ok = bus.detect_add && bus.pkt_valid && (bus.data_in[1:0] != 2'b11);
        ld_write  = bus.ld_state && !bus.fifo_full;
        ld_stall  = bus.ld_state && bus.fifo_full;
    end

    // Header capture while the FSM decodes the address; reserved address 3 is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            header_reg <= '0;
        else if (header_ok)
            header_reg <= bus.data_in;
    end

    // Output byte select: header, live byte, then the byte parked during a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dout_q <= '0;
        else if (bus.lfd_state)
            dout_q <= header_reg;
        else if (ld_write)
            dout_q <= bus.data_in;
        else if (bus.laf_state)
            dout_q <= hold_reg;
    end

    // Park the presented byte when the FIFO is full so it is written after the stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            hold_reg <= '0;
        else if (ld_stall)
            hold_reg <= bus.data_in;
    end

    // Running parity over header and payload; a stalled byte is counted when
    // parked, so laf_state never adds it a second time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            int_parity <= '0;
        else if (bus.detect_add)
            int_parity <= '0;
        else if (bus.lfd_state)
            int_parity <= int_parity ^ header_reg;
        else if (bus.ld_state && bus.pkt_valid)
            int_parity <= int_parity ^ bus.data_in;
    end

    // Capture the trailing parity byte (pkt_valid low during load_data).
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pkt_parity <= '0;
        else if (bus.ld_state && !bus.pkt_valid)
            pkt_parity <= bus.data_in;
    end

    // Flag that the source has dropped pkt_valid, i.e. the parity byte was seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            low_pkt_valid_q <= 1'b0;
        else if (bus.rst_int_reg || bus.detect_add)
            low_pkt_valid_q <= 1'b0;
        else if (bus.ld_state && !bus.pkt_valid)
            low_pkt_valid_q <= 1'b1;
    end

    // Parity byte delivered: immediately if written, otherwise once laf_state drains it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            parity_done_q <= 1'b0;
        else if (bus.detect_add)
            parity_done_q <= 1'b0;
        else if (ld_write && !bus.pkt_valid)
            parity_done_q <= 1'b1;
        else if (bus.laf_state && low_pkt_valid_q && !parity_done_q)
            parity_done_q <= 1'b1;
    end

    // Parity verdict at check time, held until the next packet loads its header.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= 1'b0;
        else if (bus.rst_int_reg)
            err_q <= (int_parity != pkt_parity);
        else if (bus.lfd_state)
            err_q <= 1'b0;
    end

`ifdef ROUTER_REG_LEN_CHECK_EN
    logic [DATA_WIDTH-3:0] count;
    logic                  len_err_q;

    // Payload byte counter, one increment per accepted payload byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (bus.lfd_state)
            count <= '0;
        else if (bus.ld_state && bus.pkt_valid)
            count <= count + 1'b1;
    end

    // Length verdict against the header length field at check time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            len_err_q <= 1'b0;
        else if (bus.rst_int_reg)
            len_err_q <= (count != header_reg[DATA_WIDTH-1:2]);
        else if (bus.lfd_state)
            len_err_q <= 1'b0;
    end

    assign bus.len_err = len_err_q;
`else
    assign bus.len_err = 1'b0;
`endif

    assign bus.dout          = dout_q;
    assign bus.parity_done   = parity_done_q;
    assign bus.low_pkt_valid = low_pkt_valid_q;
    assign bus.err           = err_q;

endmodule

// File: doc/router_reg.md
Name: router_reg

Overview:
- Datapath register stage directly downstream of the router control FSM in the 1x3 router.
- Consumes the FSM state strobes and turns the input byte stream into the byte written to the selected output FIFO (dout).
- Latches the header, holds a byte across FIFO-full stalls, accumulates running parity, and reports packet status back to the FSM: parity_done, low_pkt_valid, err.
- Packet format: header byte = {length[DATA_WIDTH-1:2], addr[1:0]}, then length payload bytes, then one parity byte equal to the XOR of the header and all payload bytes.

Parameters:
- DATA_WIDTH, 8, byte width of data_in/dout. Address field is fixed at bits [1:0].

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous reset, active-high
- pkt_valid  input  1  source strobe; high for header and payload, low on the parity byte
- data_in  input  DATA_WIDTH  source byte
- fifo_full  input  1  selected output FIFO full
- detect_add  input  1  FSM in decode_address
- lfd_state  input  1  FSM in load_first_data
- ld_state  input  1  FSM in load_data
- laf_state  input  1  FSM in load_after_full
- full_state  input  1  FSM in fifo_full_state
- rst_int_reg  input  1  FSM in check_parity_error
- dout  output  DATA_WIDTH  byte to output FIFO write port
- parity_done  output  1  parity byte has been accepted
- low_pkt_valid  output  1  pkt_valid fell during load_data
- err  output  1  parity mismatch for the last packet
- len_err  output  1  length mismatch (optional feature only)

Behaviour:
- Reset: asynchronous on rst=1. dout, header_reg, hold_reg, int_parity, pkt_parity, parity_done, low_pkt_valid, err, len_err all clear to 0.
- Header capture: if detect_add && pkt_valid && data_in[1:0]!=2'b11, then header_reg<=data_in. No change to dout.
- dout priority, highest first:
  - lfd_state: dout<=header_reg.
  - ld_state && !fifo_full: dout<=data_in.
  - laf_state: dout<=hold_reg.
  - Otherwise dout holds.
- Stall hold: if ld_state && fifo_full, hold_reg<=data_in and dout holds. The source keeps its next byte static while FSM busy is high.
- Byte accounting: each byte is accepted exactly once.
  - Header at lfd_state.
  - Payload/parity bytes at ld_state, whether written to dout or captured into hold_reg.
  - No byte is accepted in full_state or laf_state.
- int_parity:
  - Cleared on detect_add.
  - lfd_state: int_parity^=header_reg.
  - ld_state && pkt_valid: int_parity^=data_in.
  - The parity byte is never XORed in.
- pkt_parity: ld_state && !pkt_valid, then pkt_parity<=data_in.
- low_pkt_valid: set on ld_state && !pkt_valid; cleared on rst_int_reg or detect_add.
- parity_done:
  - Cleared on detect_add.
  - Set on ld_state && !fifo_full && !pkt_valid.
  - Also set on laf_state && low_pkt_valid && !parity_done.
  - Stays set until the next detect_add.
- err:
  - On rst_int_reg, err<=(int_parity!=pkt_parity).
  - Cleared on lfd_state of the next packet; holds otherwise.
- Latency: a byte present at ld_state appears on dout one cycle later. The header appears one cycle after lfd_state.
- Simultaneous events:
  - ld_state with fifo_full and !pkt_valid: the parity byte goes to both hold_reg and pkt_parity. parity_done is deferred to laf_state.
  - rst mid-packet: all state clears immediately, and the next packet starts clean.
- Reserved address 2'b11: header is not captured and dout is unchanged.

Optional Feature:
- Macro ROUTER_REG_LEN_CHECK_EN.
- When defined:
  - A DATA_WIDTH-2 bit payload counter clears on lfd_state and increments on ld_state && pkt_valid.
  - On rst_int_reg, len_err<=(count!=header_reg[DATA_WIDTH-1:2]).
  - len_err clears on lfd_state.
- When undefined: len_err is tied to 0 and no counter is built.

Test Plan:
- Header 0x0D (len 3, addr 1), payload 0x11,0x22,0x33, parity 0x0D, no full -> dout sequence 0x0D,0x11,0x22,0x33,0x0D; parity_done=1 after the parity byte; err=0 at check.
- Same packet with parity byte 0x0C -> err=1 one cycle after rst_int_reg; err clears at the next packet's lfd_state.
- fifo_full=1 in the cycle payload 0x22 is presented, released 3 cycles later -> dout holds 0x11 through full_state; dout=0x22 in the cycle after laf_state; int_parity is unaffected by the stall (err=0).
- Parity byte arrives with fifo_full=1 -> parity_done stays 0 until laf_state, then 1; low_pkt_valid=1 from ld_state until rst_int_reg.
- rst=1 asynchronously mid-payload -> all outputs 0 in the same cycle; a following clean packet passes with err=0.
- With ROUTER_REG_LEN_CHECK_EN defined, header 0x0D followed by 2 payload bytes -> len_err=1. Without the macro, len_err stays 0.
